// File: rtl/mem_access_unit.sv
// Load/store initiator for the DataMemory port: accepts one request, checks
// alignment and range, holds the bus strobes LATENCY cycles, then responds.
module mem_access_unit #(
  parameter int LATENCY   = 2,
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  DataSize,
  output logic        sign,
  input  logic [31:0] read_data
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_error_q, resp_error_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [1:0]    size_q, size_d;
  logic          sign_q, sign_d;

  logic [32:0]   nbytes;
  logic [32:0]   last_byte;
  logic          fault;

  // Last touched byte computed in 33 bits so an address wrap is caught as out of range.
  always_comb begin
    case (req_size)
      2'b01:   nbytes = 33'd1;
      2'b10:   nbytes = 33'd2;
      2'b11:   nbytes = 33'd4;
      default: nbytes = 33'd1;
    endcase
    last_byte = {1'b0, req_addr} + nbytes - 33'd1;
    fault = (req_size == 2'b00)
         || (req_size == 2'b10 && req_addr[0])
         || (req_size == 2'b11 && req_addr[1:0] != 2'b00)
         || (last_byte >= 33'(MEM_BYTES));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      size_q       <= 2'b00;
      sign_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_error_d = resp_error_q;
    resp_rdata_d = resp_rdata_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    size_d       = size_q;
    sign_d       = sign_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (fault) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = ACCESS;
            cnt_d       = CW'(LATENCY - 1);
            mem_read_d  = ~req_write;
            mem_write_d = req_write;
            addr_d      = req_addr;
            wdata_d     = req_wdata;
            size_d      = req_size;
            sign_d      = req_sign;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_rdata_d = mem_read_q ? read_data : 32'd0;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = addr_q;
  assign write_data = wdata_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign DataSize   = size_q;
  assign sign       = sign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a big-endian byte memory model
// that writes on negedge and reads combinationally.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  DataSize;
  logic        sign;
  logic [31:0] read_data;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;

  logic [7:0] mem [0:4095];

  always #5 clk = ~clk;

  mem_access_unit #(.LATENCY(2), .MEM_BYTES(4096)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .address(address), .write_data(write_data), .MemRead(MemRead), .MemWrite(MemWrite),
    .DataSize(DataSize), .sign(sign), .read_data(read_data)
  );

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (MemWrite) begin
      case (DataSize)
        2'b01: mem[address[11:0]] <= write_data[7:0];
        2'b10: begin
          mem[address[11:0]]         <= write_data[15:8];
          mem[address[11:0] + 12'd1] <= write_data[7:0];
        end
        2'b11: begin
          mem[address[11:0]]         <= write_data[31:24];
          mem[address[11:0] + 12'd1] <= write_data[23:16];
          mem[address[11:0] + 12'd2] <= write_data[15:8];
          mem[address[11:0] + 12'd3] <= write_data[7:0];
        end
        default: ;
      endcase
    end
    if (MemRead || MemWrite) strobe_cnt <= strobe_cnt + 1;
  end

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[address[11:0]];
    b1 = mem[address[11:0] + 12'd1];
    b2 = mem[address[11:0] + 12'd2];
    b3 = mem[address[11:0] + 12'd3];
    read_data = '0;
    case (DataSize)
      2'b01: read_data = sign ? {{24{b0[7]}}, b0} : {24'd0, b0};
      2'b10: read_data = sign ? {{16{b0[7]}}, b0, b1} : {16'd0, b0, b1};
      2'b11: read_data = {b0, b1, b2, b3};
      default: read_data = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
    int n;
    int guard;
    int s0;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_write = wr; req_size = sz; req_sign = sg; req_addr = ad; req_wdata = wd;
    req_valid = 1'b1;
    s0 = strobe_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".lat"}, n, exp_err ? 32'd0 : 32'd2);
    chk({tag, ".err"}, {31'd0, resp_error}, {31'd0, exp_err});
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    $display("txn %s wr=%0b size=%0d addr=%h wdata=%h -> lat=%0d err=%0b rdata=%h",
             tag, wr, sz, ad, wd, n, resp_error, resp_rdata);
    @(negedge clk);
    chk({tag, ".strobes"}, strobe_cnt - s0, exp_err ? 32'd0 : 32'd2);
    @(posedge clk); #1;
    chk({tag, ".onecyc"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int accepts, rlow, rv, good;
    repeat (2) @(negedge clk);
    chk("rst.ready", {31'd0, req_ready}, 32'd1);
    chk("rst.resp", {29'd0, resp_valid, resp_error, MemRead | MemWrite}, 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.bus", address | write_data | {29'd0, DataSize, sign}, 32'd0);
    reset = 1'b0;

    access("st_w4",   1, 2'b11, 0, 32'd4,  32'h01234567, 0, 32'd0);
    access("ld_w4",   0, 2'b11, 0, 32'd4,  32'd0,        0, 32'h01234567);
    access("st_b13",  1, 2'b01, 0, 32'd13, 32'h00000080, 0, 32'd0);
    access("ld_b13s", 0, 2'b01, 1, 32'd13, 32'd0,        0, 32'hFFFFFF80);
    access("ld_b13u", 0, 2'b01, 0, 32'd13, 32'd0,        0, 32'h00000080);
    access("st_h10",  1, 2'b10, 0, 32'd10, 32'h00004567, 0, 32'd0);
    access("ld_h10",  0, 2'b10, 0, 32'd10, 32'd0,        0, 32'h00004567);
    access("ld_w8",   0, 2'b11, 0, 32'd8,  32'd0,        0, 32'h00004567);
    access("st_h11",  1, 2'b10, 0, 32'd11, 32'hFFFFFFFF, 1, 32'd0);
    access("st_w6",   1, 2'b11, 0, 32'd6,  32'hFFFFFFFF, 1, 32'd0);
    access("st_sz0",  1, 2'b00, 0, 32'd8,  32'hFFFFFFFF, 1, 32'd0);
    access("ld_h11",  0, 2'b10, 1, 32'd11, 32'd0,        1, 32'd0);
    access("ld_w4b",  0, 2'b11, 0, 32'd4,  32'd0,        0, 32'h01234567);
    access("ld_w8b",  0, 2'b11, 0, 32'd8,  32'd0,        0, 32'h00004567);
    access("ld_w4094",0, 2'b11, 0, 32'd4094, 32'd0,      1, 32'd0);
    access("st_wtop", 1, 2'b11, 0, 32'hFFFFFFFC, 32'h1, 1, 32'd0);
    access("st_b4095",1, 2'b01, 0, 32'd4095, 32'h0000005A, 0, 32'd0);
    access("ld_b4095",0, 2'b01, 1, 32'd4095, 32'd0,      0, 32'h0000005A);
    access("ld_w4092",0, 2'b11, 0, 32'd4092, 32'd0,      0, 32'h0000005A);

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    req_write = 0; req_size = 2'b11; req_sign = 0; req_addr = 32'd4; req_valid = 1'b1;
    accepts = 0; rlow = 0; rv = 0; good = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) accepts++; else rlow++;
      @(posedge clk); #1;
      if (resp_valid) begin
        rv++;
        if (resp_rdata == 32'h01234567 && !resp_error) good++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    $display("txn stream accepts=%0d ready_low=%0d resps=%0d good=%0d", accepts, rlow, rv, good);
    chk("stream.accepts", accepts, 32'd3);
    chk("stream.rlow", rlow, 32'd9);
    chk("stream.resps", rv, 32'd3);
    chk("stream.good", good, 32'd3);

    // Reset while a store is in ACCESS.
    repeat (2) @(negedge clk);
    req_write = 1; req_size = 2'b11; req_addr = 32'd20; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid.memwrite", {31'd0, MemWrite}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid.strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    chk("mid.bus", address | write_data | {29'd0, DataSize, sign}, 32'd0);
    chk("mid.ready", {31'd0, req_ready}, 32'd1);
    chk("mid.resp", {30'd0, resp_valid, resp_error}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rv = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid) rv++;
    end
    $display("txn reset_mid_access resps_after=%0d", rv);
    chk("mid.noresp", rv, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
